// File: rtl/hy_cnt_pkg.sv
// Shared definitions for the hy_cnt programmable modulo-N timebase.
package hy_cnt_pkg;

  localparam int HY_CNT_W = 8;

  typedef logic [HY_CNT_W-1:0] hy_cnt_t;

endpackage

// File: rtl/hy_cnt_period_reg.sv
// Period shadow register: captures the requested period whenever load is high.
module hy_cnt_period_reg
  import hy_cnt_pkg::*;
#(
  parameter int C_WIDTH = HY_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [C_WIDTH-1:0] period_in,
  output logic [C_WIDTH-1:0] period_out
);

  logic [C_WIDTH-1:0] period_d;
  logic [C_WIDTH-1:0] period_q;

  always_comb begin
    period_d = period_q;
    if (load_i) begin
      period_d = period_in;
    end
  end

  // Reset branch never looks at period_in, so an undriven input cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period_out = period_q;

endmodule

// File: rtl/hy_cnt.sv
// Free-running modulo-N up-counter with a one-cycle terminal-count pulse on int_o.
module hy_cnt
  import hy_cnt_pkg::*;
#(
  parameter int C_WIDTH = HY_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_WIDTH-1:0] cnt_in,
  output logic [C_WIDTH-1:0] cnt_out,
  output logic               int_o
);

  logic [C_WIDTH-1:0] period_q;
  logic [C_WIDTH-1:0] cnt_d;
  logic [C_WIDTH-1:0] cnt_q;
  logic               int_d;
  logic               int_q;
  logic               idle;
  logic               wrap;
  logic               load;

  hy_cnt_period_reg #(
    .C_WIDTH(C_WIDTH)
  ) u_period (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .period_in (cnt_in),
    .period_out(period_q)
  );

  // Wrap compare is gated by !idle so period_q-1 never underflows into a match.
  always_comb begin
    idle  = (period_q == '0);
    wrap  = !idle && (cnt_q == (period_q - C_WIDTH'(1)));
    load  = idle || wrap;
    cnt_d = cnt_q + C_WIDTH'(1);
    int_d = wrap;
    if (load) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      int_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      int_q <= int_d;
    end
  end

  assign cnt_out = cnt_q;
  assign int_o   = int_q;

endmodule

// File: tb/tb_hy_cnt.sv
// Self-checking bench for hy_cnt: vector table plus scoreboarded corner-case sequences.
module tb_hy_cnt;
  import hy_cnt_pkg::*;

  typedef struct {
    logic    rst;
    hy_cnt_t cin;
    hy_cnt_t cnt;
    logic    irq;
  } vec_t;

  typedef struct {
    hy_cnt_t cnt;
    logic    irq;
    string   nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  hy_cnt_t    cnt_in;
  hy_cnt_t    cnt_out;
  logic       int_o;

  logic       rst4;
  logic [3:0] cin4;
  logic [3:0] cnt4;
  logic       irq4;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  exp_t sbq[$];

  // Reference model state
  hy_cnt_t m_per;
  hy_cnt_t m_cnt;
  logic    m_int;

  always #5 clk = ~clk;

  hy_cnt #(.C_WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_in (cnt_in),
    .cnt_out(cnt_out),
    .int_o  (int_o)
  );

  hy_cnt #(.C_WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .cnt_in (cin4),
    .cnt_out(cnt4),
    .int_o  (irq4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_edge(input logic r, input hy_cnt_t ci);
    if (r) begin
      m_per = '0; m_cnt = '0; m_int = 1'b0;
    end else if (m_per == '0) begin
      m_per = ci; m_cnt = '0; m_int = 1'b0;
    end else if (m_cnt == m_per - 8'd1) begin
      m_per = ci; m_cnt = '0; m_int = 1'b1;
    end else begin
      m_cnt = m_cnt + 8'd1; m_int = 1'b0;
    end
  endtask

  // Drive on the falling edge, push expectation, compare after the rising edge.
  task automatic apply(input logic r, input hy_cnt_t ci, input hy_cnt_t ecnt,
                       input logic eirq, input string nm);
    exp_t e;
    @(negedge clk);
    rst    = r;
    cnt_in = ci;
    sbq.push_back('{cnt: ecnt, irq: eirq, nm: nm});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      check({e.nm, ".cnt"}, 32'(cnt_out), 32'(e.cnt));
      check({e.nm, ".int"}, 32'(int_o), 32'(e.irq));
    end
  endtask

  task automatic step(input logic r, input hy_cnt_t ci, input string nm);
    model_edge(r, ci);
    apply(r, ci, m_cnt, m_int, nm);
  endtask

  initial begin
    int ints;
    int maxc;
    int last_int;
    int gap;
    rst    = 1'b1;
    cnt_in = 'x;
    rst4   = 1'b1;
    cin4   = '0;

    // Reset with X input, startup at N=5, mid-period change to 3, zero period, resume at 4
    tbl.push_back('{1'b1, 8'hxx, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 8'hxx, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd3, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd4, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 8'd5, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 8'd5, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 8'd3, 8'd3, 1'b0});
    tbl.push_back('{1'b0, 8'd3, 8'd4, 1'b0});
    tbl.push_back('{1'b0, 8'd3, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 8'd3, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 8'd3, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 8'd3, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 8'd3, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 8'd0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd4, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 8'd4, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 8'd4, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 8'd4, 8'd3, 1'b0});
    tbl.push_back('{1'b0, 8'd4, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 8'd4, 8'd1, 1'b0});

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].cin, tbl[i].cnt, tbl[i].irq, $sformatf("vec%0d", i));
    end

    // N=1: counter pinned at 0, pulse every cycle after the load edge
    step(1'b1, 8'd1, "n1_rst");
    for (int i = 0; i < 8; i++) step(1'b0, 8'd1, $sformatf("n1_%0d", i));
    check("n1_int_high", 32'(int_o), 32'd1);

    // N=5 over 1000 cycles: 200 pulses give or take one
    step(1'b1, 8'd5, "n5_rst");
    ints = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 8'd5, "n5_run");
      if (int_o === 1'b1) ints++;
    end
    check("n5_int_count_ok", 32'((ints >= 199) && (ints <= 201)), 32'd1);

    // N=255: reaches 254 and pulses every 255 cycles
    step(1'b1, 8'd255, "n255_rst");
    maxc = 0; last_int = -1; gap = 0;
    for (int i = 0; i < 520; i++) begin
      step(1'b0, 8'd255, "n255_run");
      if (int'(cnt_out) > maxc) maxc = int'(cnt_out);
      if (int_o === 1'b1) begin
        if (last_int >= 0) gap = i - last_int;
        last_int = i;
      end
    end
    check("n255_max_cnt", 32'(maxc), 32'd254);
    check("n255_period", 32'(gap), 32'd255);

    // Reset asserted at the wrap point wins over the pulse
    step(1'b1, 8'd4, "rm_rst");
    for (int i = 0; i < 6; i++) step(1'b0, 8'd4, "rm_run");
    while (m_cnt != 8'd3) step(1'b0, 8'd4, "rm_seek");
    apply(1'b1, 8'd4, 8'd0, 1'b0, "rm_reset_at_wrap");
    m_per = '0; m_cnt = '0; m_int = 1'b0;
    apply(1'b0, 8'd4, 8'd0, 1'b0, "rm_load");
    apply(1'b0, 8'd4, 8'd1, 1'b0, "rm_first");
    m_per = 8'd4; m_cnt = 8'd1;
    for (int i = 0; i < 5; i++) step(1'b0, 8'd4, "rm_after");

    // 4-bit instance at its maximum period
    @(negedge clk);
    rst4 = 1'b1;
    cin4 = 4'd15;
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk);
    #1;
    check("w4_load.cnt", 32'(cnt4), 32'd0);
    check("w4_load.int", 32'(irq4), 32'd0);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("w4_%0d.cnt", k), 32'(cnt4), 32'(k % 15));
      check($sformatf("w4_%0d.int", k), 32'(irq4), 32'((k % 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
